// File: rtl/poly_tile_conv_modq.sv
// Tiled schoolbook polynomial multiplier: C = A*B mod (x^N +/- 1), coefficients mod Q.
// Streams A/B in as N/T beats, accumulates T products per cycle, streams C out as N/T beats.
module poly_tile_conv_modq #(
  parameter int DATA_WIDTH = 16,
  parameter int POLY_WIDTH = 64,
  parameter int TILE_WIDTH = 8,
  parameter int MODULUS    = 12289
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  inputs_ready_signal,
  output logic                                  in_ready,
  input  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_a,
  input  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_b,
  input  logic                                  negacyclic,
  output logic                                  outputs_ready_signal,
  input  logic                                  out_ready,
  output logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] c_value_outputs,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done
);

  localparam int N  = POLY_WIDTH;
  localparam int T  = TILE_WIDTH;
  localparam int NB = POLY_WIDTH / TILE_WIDTH;
  localparam int W  = DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [IW-1:0]  I_LAST = IW'(N - 1);
  localparam logic [BW-1:0]  B_LAST = BW'(NB - 1);
  localparam logic [IW:0]    NK     = (IW + 1)'(N);
  localparam logic [W-1:0]   QW     = W'(MODULUS);
  localparam logic [2*W-1:0] QP     = (2 * W)'(MODULUS);

  function automatic logic [W-1:0] red_q(input logic [W-1:0] x);
    return x % QW;
  endfunction

  function automatic logic [W-1:0] mul_q(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(prod % QP);
  endfunction

  function automatic logic [W-1:0] add_q(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, QW}) s = s - {1'b0, QW};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_q(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x >= y) ? (x - y) : (x + (QW - y));
  endfunction

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  state_t                state_q;
  logic [BW-1:0]         beat_q, t_q, m_q;
  logic [IW-1:0]         i_q;
  logic                  neg_q, ovld_q, last_q, done_q;
  logic [T-1:0][W-1:0]   cout_q;
  logic [W-1:0]          a_q   [N];
  logic [W-1:0]          b_q   [N];
  logic [W-1:0]          acc_q [N];

  logic                  accept, last_beat;
  logic [IW-1:0]         jj  [T];
  logic [IW:0]           kk  [T];
  logic                  wrap[T];
  logic [IW-1:0]         tgt [T];
  logic [W-1:0]          prd [T];
  logic [W-1:0]          upd [T];
  logic [BW-1:0]         m_sel;
  logic [T-1:0][W-1:0]   tile_nxt;

  assign accept    = (state_q == LOAD) && inputs_ready_signal;
  assign last_beat = accept && (beat_q == B_LAST);

  // One (i,t) pair per cycle: T products a[i]*b[tT+j] folded onto distinct accumulators.
  always_comb begin
    for (int j = 0; j < T; j++) begin
      jj[j]   = IW'(int'(t_q) * T + j);
      kk[j]   = {1'b0, i_q} + {1'b0, jj[j]};
      wrap[j] = (kk[j] >= NK);
      tgt[j]  = wrap[j] ? IW'(kk[j] - NK) : kk[j][IW-1:0];
      prd[j]  = mul_q(a_q[i_q], b_q[jj[j]]);
      upd[j]  = (wrap[j] && neg_q) ? sub_q(acc_q[tgt[j]], prd[j])
                                   : add_q(acc_q[tgt[j]], prd[j]);
    end
  end

  // While a beat is presented the next tile is prefetched so handshakes can run back to back.
  always_comb begin
    m_sel = ovld_q ? (m_q + 1'b1) : m_q;
    for (int j = 0; j < T; j++) begin
      tile_nxt[j] = acc_q[IW'(int'(m_sel) * T + j)];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < T; j++) begin
        a_q[IW'(int'(beat_q) * T + j)] <= red_q(tile_a[j]);
        b_q[IW'(int'(beat_q) * T + j)] <= red_q(tile_b[j]);
      end
      if (beat_q == '0) neg_q <= negacyclic;
    end
    if (last_beat) begin
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
    end else if (state_q == COMPUTE) begin
      for (int j = 0; j < T; j++) acc_q[tgt[j]] <= upd[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      beat_q  <= '0;
      t_q     <= '0;
      i_q     <= '0;
      m_q     <= '0;
      ovld_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (beat_q == B_LAST) begin
              beat_q  <= '0;
              i_q     <= '0;
              t_q     <= '0;
              state_q <= COMPUTE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (t_q == B_LAST) begin
            t_q <= '0;
            if (i_q == I_LAST) begin
              i_q     <= '0;
              m_q     <= '0;
              state_q <= DRAIN;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!ovld_q) begin
            ovld_q <= 1'b1;
            cout_q <= tile_nxt;
            last_q <= (m_sel == B_LAST);
          end else if (out_ready) begin
            if (m_q == B_LAST) begin
              ovld_q  <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              m_q     <= '0;
              state_q <= LOAD;
            end else begin
              m_q    <= m_sel;
              cout_q <= tile_nxt;
              last_q <= (m_sel == B_LAST);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready             = (state_q == LOAD);
  assign busy                 = (state_q != LOAD);
  assign outputs_ready_signal = ovld_q;
  assign c_value_outputs      = cout_q;
  assign out_last             = last_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_poly_tile_conv_modq.sv
// Directed bench for poly_tile_conv_modq at default parameters (N=64, T=8, Q=12289).
module tb_poly_tile_conv_modq;

  localparam int W  = 16;
  localparam int N  = 64;
  localparam int T  = 8;
  localparam int NB = N / T;
  localparam int Q  = 12289;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                inputs_ready_signal = 1'b0;
  logic                in_ready;
  logic [T-1:0][W-1:0] tile_a = '0;
  logic [T-1:0][W-1:0] tile_b = '0;
  logic                negacyclic = 1'b0;
  logic                outputs_ready_signal;
  logic                out_ready = 1'b0;
  logic [T-1:0][W-1:0] c_value_outputs;
  logic                out_last;
  logic                busy;
  logic                done;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] va [N];
  logic [15:0] vb [N];
  int          exp_c [N];
  int          res [N];
  int          lat;

  poly_tile_conv_modq #(
    .DATA_WIDTH(W), .POLY_WIDTH(N), .TILE_WIDTH(T), .MODULUS(Q)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .inputs_ready_signal (inputs_ready_signal),
    .in_ready            (in_ready),
    .tile_a              (tile_a),
    .tile_b              (tile_b),
    .negacyclic          (negacyclic),
    .outputs_ready_signal(outputs_ready_signal),
    .out_ready           (out_ready),
    .c_value_outputs     (c_value_outputs),
    .out_last            (out_last),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_vectors(input logic [15:0] av, input logic [15:0] bv);
    for (int k = 0; k < N; k++) begin
      va[k] = av;
      vb[k] = bv;
    end
  endtask

  // negacyclic is inverted on beats 1..7 so only the beat-0 sample may matter.
  task automatic load_job(input logic neg);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      if (k == 0) check_val("in_ready_load", in_ready, 1'b1);
      inputs_ready_signal = 1'b1;
      negacyclic = (k == 0) ? neg : ~neg;
      for (int j = 0; j < T; j++) begin
        tile_a[j] = va[k * T + j];
        tile_b[j] = vb[k * T + j];
      end
      @(posedge clk);
    end
    #1;
    tile_a = {T{16'h7777}};
    tile_b = {T{16'h1234}};
    check_val("busy_compute", busy, 1'b1);
    check_val("in_ready_compute", in_ready, 1'b0);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (outputs_ready_signal) break;
    end
    inputs_ready_signal = 1'b0;
    if (!outputs_ready_signal) check_val("valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input int stall_beat, input int stall_len);
    int           m = 0;
    int           guard = 0;
    int           st = 0;
    int           dn = 0;
    logic [127:0] held = '0;
    logic         held_last = 1'b0;
    while (m < NB && guard < 400) begin
      @(negedge clk);
      guard++;
      if (done) dn++;
      if (outputs_ready_signal) begin
        if (m == stall_beat && st < stall_len) begin
          if (st == 0) begin
            held = c_value_outputs;
            held_last = out_last;
          end else begin
            check_val("stall_data", c_value_outputs, held);
            check_val("stall_last", out_last, held_last);
          end
          out_ready = 1'b0;
          st++;
        end else begin
          if (m == stall_beat) check_val("stall_data_end", c_value_outputs, held);
          for (int j = 0; j < T; j++) res[m * T + j] = int'(c_value_outputs[j]);
          check_val($sformatf("out_last_b%0d", m), out_last, (m == NB - 1));
          out_ready = 1'b1;
          m++;
        end
      end else begin
        out_ready = 1'b0;
        if (m == stall_beat && st > 0) check_val("stall_valid", 1'b0, 1'b1);
      end
    end
    if (m < NB) check_val("drain_timeout", m, NB);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("done_pulse", done, 1'b1);
    check_val("busy_after", busy, 1'b0);
    check_val("in_ready_after", in_ready, 1'b1);
    check_val("valid_after", outputs_ready_signal, 1'b0);
    @(negedge clk);
    check_val("done_cleared", done, 1'b0);
    check_val("done_early", dn, 0);
    if (stall_beat >= 0) check_val("stall_cycles", st, stall_len);
  endtask

  task automatic check_result(input string name);
    for (int k = 0; k < N; k++) check_val($sformatf("%s_c%0d", name, k), res[k], exp_c[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", outputs_ready_signal, 1'b0);
    check_val("rst_last", out_last, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_c", c_value_outputs, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_in_ready", in_ready, 1'b1);

    // All ones, cyclic: each c[k] sums 64 unit products.
    set_vectors(16'd1, 16'd1);
    for (int k = 0; k < N; k++) exp_c[k] = 64;
    load_job(1'b0);
    wait_valid(lat);
    check_val("latency_ones", lat, 513);
    drain(-1, 0);
    check_result("ones_cyc");

    // All ones, negacyclic, with a 10-cycle stall on beat 3.
    for (int k = 0; k < N; k++) exp_c[k] = (2 * k + 2 - 64 + Q) % Q;
    load_job(1'b1);
    wait_valid(lat);
    drain(3, 10);
    check_result("ones_neg");
    check_val("neg_c0", res[0], 12227);
    check_val("neg_c31", res[31], 0);
    check_val("neg_c63", res[63], 64);

    // x^63 * x: wraps to index 0 with sign set by the reduction mode.
    set_vectors(16'd0, 16'd0);
    va[63] = 16'd1;
    vb[1]  = 16'd1;
    for (int k = 0; k < N; k++) exp_c[k] = 0;
    exp_c[0] = 12288;
    load_job(1'b1);
    wait_valid(lat);
    drain(-1, 0);
    check_result("wrap_neg");
    exp_c[0] = 1;
    load_job(1'b0);
    wait_valid(lat);
    drain(-1, 0);
    check_result("wrap_cyc");

    // Input above Q is reduced on store: 12290 -> 1, times 2.
    set_vectors(16'd0, 16'd0);
    va[0] = 16'd12290;
    vb[0] = 16'd2;
    exp_c[0] = 2;
    load_job(1'b0);
    wait_valid(lat);
    check_val("latency_red", lat, 513);
    drain(-1, 0);
    check_result("reduce");

    // Reset in the middle of COMPUTE discards the job.
    set_vectors(16'd1, 16'd1);
    load_job(1'b1);
    inputs_ready_signal = 1'b0;
    repeat (199) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("mid_rst_valid", outputs_ready_signal, 1'b0);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_last", out_last, 1'b0);
    check_val("mid_rst_done", done, 1'b0);
    check_val("mid_rst_c", c_value_outputs, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_in_ready", in_ready, 1'b1);
    for (int k = 0; k < N; k++) exp_c[k] = 64;
    load_job(1'b0);
    wait_valid(lat);
    check_val("latency_post_rst", lat, 513);
    drain(-1, 0);
    check_result("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_tile_conv_modq.md
POLY_TILE_CONV_MODQ -- requirements
Module: poly_tile_conv_modq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: coefficient width in bits.
REQ-002 SHALL have parameter POLY_WIDTH, default 64: coefficients per polynomial (N); POLY_WIDTH SHALL be divisible by TILE_WIDTH.
REQ-003 SHALL have parameter TILE_WIDTH, default 8: coefficients per transfer beat and parallel multipliers (T).
REQ-004 SHALL have parameter MODULUS, default 12289: coefficient modulus Q, with 2 <= Q < 2^(DATA_WIDTH-1).
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port inputs_ready_signal, input, 1: input beat valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts an input beat.
REQ-009 SHALL have port tile_a, input, [T][DATA_WIDTH]: T coefficients of A, lowest index in element 0.
REQ-010 SHALL have port tile_b, input, [T][DATA_WIDTH]: T coefficients of B, same ordering as tile_a.
REQ-011 SHALL have port negacyclic, input, 1: reduction mode; 1 = mod x^N+1, 0 = mod x^N-1.
REQ-012 SHALL have port outputs_ready_signal, output, 1: output beat valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts an output beat.
REQ-014 SHALL have port c_value_outputs, output, [T][DATA_WIDTH]: T coefficients of C.
REQ-015 SHALL have port out_last, output, 1: marks the final output beat.
REQ-016 SHALL have port busy, output, 1: high in COMPUTE or DRAIN.
REQ-017 SHALL have port done, output, 1: one-cycle pulse after the final output handshake.

Function
REQ-018 SHALL compute C = A*B mod (x^N +/- 1), with every coefficient of C in [0, Q).
REQ-019 SHALL use an FSM with three states: LOAD, COMPUTE, DRAIN.
REQ-020 LOAD SHALL assert in_ready=1 and accept a beat when inputs_ready_signal && in_ready.
REQ-021 Beat k (k = 0 .. N/T-1) SHALL write a[kT+j] and b[kT+j], j < T.
REQ-022 Each coefficient SHALL be reduced mod Q when stored, so inputs >= Q are legal.
REQ-023 negacyclic SHALL be sampled on beat 0 only and held for the whole job.
REQ-024 The accepted beat N/T-1 SHALL clear all N accumulators and transition to COMPUTE.
REQ-025 COMPUTE SHALL iterate i = 0..N-1 (outer) and block t = 0..N/T-1 (inner), one (i,t) pair per cycle, for N*N/T cycles total.
REQ-026 In each (i,t) cycle, for each j in [tT, tT+T): p = (a[i]*b[j]) mod Q using a full 2*DATA_WIDTH product; k = i+j.
REQ-027 If k < N, acc[k] SHALL become (acc[k]+p) mod Q.
REQ-028 If k >= N, the target index SHALL be k-N; the update SHALL be (acc+p) mod Q when negacyclic=0 and (acc-p) mod Q when negacyclic=1.
REQ-029 Within one cycle the T target indices are distinct, so no accumulate collision SHALL occur.
REQ-030 After the last (i,t) cycle the block SHALL enter DRAIN.
REQ-031 DRAIN SHALL register outputs_ready_signal=1 with c_value_outputs = acc[mT +: T] for output beat m.
REQ-032 The beat index m SHALL advance only on outputs_ready_signal && out_ready.
REQ-033 out_last SHALL be 1 when m = N/T-1.
REQ-034 While out_ready=0 in DRAIN, c_value_outputs and out_last SHALL hold stable.
REQ-035 The final output handshake SHALL return the FSM to LOAD and pulse done on the next cycle.
REQ-036 in_ready SHALL be 0 in COMPUTE and DRAIN; inputs_ready_signal there SHALL be ignored.
REQ-037 Latency: the first outputs_ready_signal SHALL rise exactly N*N/T + 1 cycles after the clock edge accepting the last input beat (513 at defaults).
REQ-038 Back-to-back jobs: a new job SHALL be accepted in the cycle after the final output handshake.

Reset
REQ-039 rst=0 SHALL asynchronously force: state LOAD, counters 0, in_ready=1 after release, outputs_ready_signal=0, out_last=0, busy=0, done=0, c_value_outputs=0.
REQ-040 Reset in any state, mid-load or mid-compute, SHALL discard the partial job; coefficient and accumulator storage need not be cleared.

Verification
REQ-041 All-ones A and B, negacyclic=0 -> every C coefficient = 64.
REQ-042 All-ones A and B, negacyclic=1 -> c[k] = (2k+2-64) mod 12289; c[0]=12227, c[31]=0, c[63]=64.
REQ-043 a[63]=1, b[1]=1, all other coefficients 0 -> negacyclic=1: c[0]=12288, all others 0; negacyclic=0: c[0]=1, all others 0.
REQ-044 a[0]=12290, b[0]=2, all other coefficients 0 -> c[0]=2; the first outputs_ready_signal rises exactly 513 cycles after the last input beat.
REQ-045 out_ready held 0 for 10 cycles on output beat 3 -> c_value_outputs stable, outputs_ready_signal held at 1; all 8 beats delivered in order, with out_last on beat 7 and done pulsed once.
REQ-046 rst pulsed low at COMPUTE cycle 200 -> all outputs return to reset values; a following job with all-ones inputs and negacyclic=0 yields all 64.
